// File: rtl/efuse_ctrl_if.sv
// Host and driver-side signal bundle for the eFuse sequencer.
// slave = the controller, master = the environment (host + efuse_driver).
interface efuse_ctrl_if;
  // host side
  logic        host_rd_req;
  logic        host_pg_req;
  logic [31:0] host_pg_data;
  logic [31:0] host_key;
  logic        host_busy;
  logic        host_done;
  logic [1:0]  host_err;
  logic [31:0] trim_data;
  logic        trim_valid;
  logic        boot_err;
  // efuse_driver side
  logic        drv_read_start;
  logic        drv_read_ack;
  logic [31:0] drv_dout;
  logic        drv_dout_valid;
  logic        drv_prog_start;
  logic [31:0] drv_efuse_din;
  logic        drv_prog_ack;

  modport slave (
    input  host_rd_req, host_pg_req, host_pg_data, host_key,
    output host_busy, host_done, host_err, trim_data, trim_valid, boot_err,
    output drv_read_start, drv_prog_start, drv_efuse_din,
    input  drv_read_ack, drv_dout, drv_dout_valid, drv_prog_ack
  );

  modport master (
    output host_rd_req, host_pg_req, host_pg_data, host_key,
    input  host_busy, host_done, host_err, trim_data, trim_valid, boot_err,
    input  drv_read_start, drv_prog_start, drv_efuse_din,
    output drv_read_ack, drv_dout, drv_dout_valid, drv_prog_ack
  );
endinterface

// File: rtl/efuse_ctrl.sv
// eFuse sequencer: boot auto-load into a trim shadow, host read/program with
// read-back verify, unlock-key and lock-bit guard, timeouts and boot retries.
module efuse_ctrl #(
  parameter logic [15:0] BOOT_DELAY = 16'd1000,
  parameter logic [7:0]  ACK_TMO    = 8'd32,
  parameter logic [15:0] OP_TMO     = 16'd40000,
  parameter logic [15:0] PROG_WAIT  = 16'd20000,
  parameter logic [31:0] UNLOCK_KEY = 32'hA5C3_5A3C,
  parameter logic [1:0]  BOOT_RETRY = 2'd2
) (
  input  logic         clk,
  input  logic         rstn,
  efuse_ctrl_if.slave  bus
);

  typedef enum logic [3:0] {
    BOOT_WAIT, IDLE, RD_REQ, RD_WAIT, PG_REQ, PG_WAIT, VFY_REQ, VFY_WAIT, DONE
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] cnt;
  logic [1:0]  att;
  logic        boot_q, dv_q, cap_vld;
  logic [31:0] cap, trim_q, din_q;
  logic        trim_vld_q, boot_err_q, busy_q;
  logic [1:0]  err_q;

  // next-state side strobes
  logic        tmo, retry, err_set, shadow_upd, boot_fail, din_ld, boot_start, boot_end;
  logic [1:0]  err_val;
  // output comb
  logic        rd_start, pg_start, done;

  logic wait_st, rise, ack_tmo, op_tmo, cnt_clr, cap_now;

  assign wait_st = (state == RD_WAIT) || (state == VFY_WAIT);
  assign rise    = bus.drv_dout_valid & ~dv_q;
  assign cap_now = wait_st & rise & ~cap_vld;
  assign ack_tmo = cnt >= ({8'd0, ACK_TMO} - 16'd1);
  assign op_tmo  = cnt >= (OP_TMO - 16'd1);
  // counter restarts on every state entry, including a boot retry into RD_REQ
  assign cnt_clr = (state_nxt != state) || retry;

  // state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= BOOT_WAIT;
    else       state <= state_nxt;
  end

  // next state and datapath strobes
  always_comb begin
    state_nxt  = state;
    tmo        = 1'b0;
    retry      = 1'b0;
    err_set    = 1'b0;
    err_val    = 2'b00;
    shadow_upd = 1'b0;
    boot_fail  = 1'b0;
    din_ld     = 1'b0;
    boot_start = 1'b0;
    boot_end   = 1'b0;
    case (state)
      BOOT_WAIT: if (cnt >= BOOT_DELAY - 16'd1) begin
        state_nxt  = RD_REQ;
        boot_start = 1'b1;
      end
      IDLE: begin
        // read wins over a simultaneous program request
        if (bus.host_rd_req) state_nxt = RD_REQ;
        else if (bus.host_pg_req) begin
          if (bus.host_key != UNLOCK_KEY || (trim_vld_q && trim_q[31])) begin
            state_nxt = DONE;
            err_set   = 1'b1;
            err_val   = 2'b01;
          end else begin
            state_nxt = PG_REQ;
            din_ld    = 1'b1;
          end
        end
      end
      RD_REQ, VFY_REQ: begin
        if (bus.drv_read_ack) state_nxt = (state == RD_REQ) ? RD_WAIT : VFY_WAIT;
        else if (ack_tmo)     tmo = 1'b1;
      end
      PG_REQ: begin
        if (bus.drv_prog_ack) state_nxt = PG_WAIT;
        else if (ack_tmo)     tmo = 1'b1;
      end
      PG_WAIT: if (cnt >= PROG_WAIT - 16'd1) state_nxt = VFY_REQ;
      RD_WAIT, VFY_WAIT: begin
        if (cap_vld) begin
          shadow_upd = 1'b1;
          if (state == VFY_WAIT) begin
            state_nxt = DONE;
            err_set   = 1'b1;
            err_val   = ((cap & din_q) == din_q) ? 2'b00 : 2'b11;
          end else if (boot_q) begin
            state_nxt = IDLE;
            boot_end  = 1'b1;
          end else begin
            state_nxt = DONE;
            err_set   = 1'b1;
          end
        end else if (op_tmo && !rise) tmo = 1'b1;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // shared timeout handling: boot retries, host ops report err=10
    if (tmo) begin
      if (boot_q) begin
        if (att < BOOT_RETRY) begin
          state_nxt = RD_REQ;
          retry     = 1'b1;
        end else begin
          state_nxt = IDLE;
          boot_fail = 1'b1;
          boot_end  = 1'b1;
        end
      end else begin
        state_nxt = DONE;
        err_set   = 1'b1;
        err_val   = 2'b10;
      end
    end
  end

  // driver pulses fire on the first cycle of a request state; host_done in DONE
  always_comb begin
    rd_start = ((state == RD_REQ) || (state == VFY_REQ)) && (cnt == 16'd0);
    pg_start = (state == PG_REQ) && (cnt == 16'd0);
    done     = (state == DONE);
  end

  // counters, capture path, shadow and status registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt        <= '0;
      att        <= '0;
      boot_q     <= 1'b0;
      dv_q       <= 1'b0;
      cap_vld    <= 1'b0;
      cap        <= '0;
      trim_q     <= '0;
      trim_vld_q <= 1'b0;
      din_q      <= '0;
      err_q      <= '0;
      boot_err_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      cnt     <= cnt_clr ? 16'd0 : ((cnt == 16'hFFFF) ? cnt : cnt + 16'd1);
      dv_q    <= bus.drv_dout_valid;
      cap_vld <= cap_now;
      if (cap_now)    cap <= bus.drv_dout;
      if (shadow_upd) begin
        trim_q     <= cap;
        trim_vld_q <= 1'b1;
      end
      if (din_ld)     din_q      <= bus.host_pg_data;
      if (err_set)    err_q      <= err_val;
      if (boot_fail)  boot_err_q <= 1'b1;
      if (boot_start) begin
        boot_q <= 1'b1;
        att    <= 2'd0;
      end else if (boot_end) boot_q <= 1'b0;
      if (retry && att != 2'b11) att <= att + 2'd1;
      // registered so it reads 0 while reset is held
      busy_q  <= (state_nxt != IDLE);
    end
  end

  assign bus.host_busy      = busy_q;
  assign bus.host_done      = done;
  assign bus.host_err       = err_q;
  assign bus.trim_data      = trim_q;
  assign bus.trim_valid     = trim_vld_q;
  assign bus.boot_err       = boot_err_q;
  assign bus.drv_read_start = rd_start;
  assign bus.drv_prog_start = pg_start;
  assign bus.drv_efuse_din  = din_q;

endmodule
